// File: rtl/memory_write_responder_pkg.sv
// Shared types for the data-memory store responder: register values, word
// addresses, the buffered store record and the drain FSM encoding.
package memory_write_responder_pkg;

    typedef logic [31:0] regval_t;
    typedef logic [29:0] mem_word_t;

    typedef struct packed {
        mem_word_t address;
        regval_t   data;
    } store_t;

    localparam int DefaultWriteDepth = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } drain_state_e;

    function automatic mem_word_t word_address(input regval_t byte_address);
        return byte_address[31:2];
    endfunction

endpackage

// File: rtl/memory_write_responder_store_fifo.sv
// Synchronous FIFO of store records used as the posted-write buffer.
// A push is honoured when full only if a pop happens in the same cycle.
module store_fifo
    import memory_write_responder_pkg::*;
#(
    parameter int DEPTH = DefaultWriteDepth
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   push,
    input  store_t                 push_data,
    input  logic                   pop,
    output store_t                 pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PtrOne   = AW'(1);
    localparam logic [CW-1:0] CountOne = CW'(1);
    localparam logic [CW-1:0] CountMax = CW'(DEPTH);

    store_t        storage_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok_s, pop_ok_s;

    assign full      = (count_q == CountMax);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign pop_data  = storage_q[rd_ptr_q];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Next pointer and occupancy values.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok_s) begin
            wr_ptr_d = wr_ptr_q + PtrOne;
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_ok_s) begin
            rd_ptr_d = rd_ptr_q + PtrOne;
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + CountOne;
            2'b01:   count_d = count_q - CountOne;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            storage_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/memory_write_responder.sv
// Store handshake responder between the write stage and the data-memory bus.
// Build option POSTED_WRITE_EN inserts a DEPTH-entry posted-write FIFO.
module memory_write_responder
    import memory_write_responder_pkg::*;
#(
    parameter int DEPTH = DefaultWriteDepth
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        address_enable,
    input  logic [31:0] address,
    input  logic [31:0] data,
    output logic        data_valid,
    output logic        mem_write,
    output logic [29:0] mem_address,
    output logic [31:0] mem_data,
    input  logic        mem_ack,
    output logic        drained
);

    if (DEPTH < 32'sd2 || (DEPTH & (DEPTH - 32'sd1)) != 32'sd0) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end

    drain_state_e state_q, state_d;
    logic         data_valid_q, data_valid_d;
    logic         mem_write_q, mem_write_d;
    mem_word_t    mem_address_q, mem_address_d;
    regval_t      mem_data_q, mem_data_d;

    store_t req_s, head_s;
    logic   ack_s, accept_s, slot_available_s, pending_s, buffer_empty_s;
    logic   unused_byte_offset_s;

    assign req_s                = '{address: word_address(address), data: data};
    assign unused_byte_offset_s = ^address[1:0];
    assign ack_s                = mem_write_q && mem_ack;
    // The !data_valid term blocks a second accept of a request in its ack cycle.
    assign accept_s             = address_enable && !data_valid_q && slot_available_s;

`ifdef POSTED_WRITE_EN
    logic                   fifo_full_s, fifo_empty_s;
    logic [$clog2(DEPTH):0] fifo_count_s;

    // The head entry stays buffered until the bus acknowledges it.
    store_fifo #(
        .DEPTH(DEPTH)
    ) u_store_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .push     (accept_s),
        .push_data(req_s),
        .pop      (ack_s),
        .pop_data (head_s),
        .full     (fifo_full_s),
        .empty    (fifo_empty_s),
        .count    (fifo_count_s)
    );

    assign slot_available_s = !fifo_full_s || ack_s;
    assign pending_s        = !fifo_empty_s;
    assign buffer_empty_s   = (fifo_count_s == '0);
`else
    // Write-through: the bus registers double as the single holding register.
    assign slot_available_s = (state_q == ST_IDLE);
    assign head_s           = req_s;
    assign pending_s        = accept_s;
    assign buffer_empty_s   = 1'b1;
`endif

    // Drain FSM next state and next values of the registered outputs.
    always_comb begin
        state_d       = state_q;
        mem_write_d   = mem_write_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
`ifdef POSTED_WRITE_EN
        data_valid_d  = accept_s;
`else
        data_valid_d  = ack_s;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pending_s) begin
                    state_d       = ST_ISSUE;
                    mem_write_d   = 1'b1;
                    mem_address_d = head_s.address;
                    mem_data_d    = head_s.data;
                end else begin
                    state_d       = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (ack_s) begin
                    state_d     = ST_IDLE;
                    mem_write_d = 1'b0;
                end else begin
                    state_d     = ST_ISSUE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                mem_write_d = 1'b0;
            end
        endcase
    end

    // Drain FSM state and registered handshake/bus outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            data_valid_q  <= 1'b0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            data_valid_q  <= data_valid_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
        end
    end

    assign data_valid  = data_valid_q;
    assign mem_write   = mem_write_q;
    assign mem_address = mem_address_q;
    assign mem_data    = mem_data_q;
    assign drained     = (state_q == ST_IDLE) && buffer_empty_s && !accept_s;

endmodule

// File: tb/tb_memory_write_responder.sv
// Self-checking bench for memory_write_responder: a queue-based store model
// checked every cycle, plus directed vectors with hand-computed results.
module tb_memory_write_responder;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ae;
    logic [31:0] address, data;
    logic        mem_ack;
    logic        data_valid, mem_write, drained;
    logic [29:0] mem_address;
    logic [31:0] mem_data;

    always #5 clk = ~clk;

    memory_write_responder #(.DEPTH(DEPTH)) dut (
        .clock         (clk),
        .reset_n       (rst_n),
        .address_enable(ae),
        .address       (address),
        .data          (data),
        .data_valid    (data_valid),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_data      (mem_data),
        .mem_ack       (mem_ack),
        .drained       (drained)
    );

    typedef struct {
        logic [29:0] a;
        logic [31:0] d;
    } st_t;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        int          dly;
        logic [29:0] w;
    } vec_t;

    int  tests = 0;
    int  fails = 0;
    int  cyc = 0;
    int  dv_seen = 0;
    int  dv_cyc = 0;
    int  mw_rise_cyc = 0;
    bit  prev_dv = 1'b0;
    bit  prev_mw = 1'b0;
    st_t bus_log[$];

    // Reference model: pending stores in acceptance order plus expected outputs.
    st_t         mq[$];
    bit          exp_dv = 1'b0;
    bit          exp_mw = 1'b0;
    logic [29:0] exp_addr = '0;
    logic [31:0] exp_data = '0;

    bit auto_ack = 1'b0;
    int ack_delay = 0;
    int ack_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic bit model_accept();
`ifdef POSTED_WRITE_EN
        return ae && !exp_dv && ((mq.size() < DEPTH) || (exp_mw && mem_ack));
`else
        return ae && !exp_dv && !exp_mw;
`endif
    endfunction

    function automatic bit model_drained();
        return !exp_mw && (mq.size() == 0) && !model_accept();
    endfunction

    always @(posedge clk) cyc++;

    // Model update from the spec's acceptance, ack and ordering rules.
    always @(posedge clk or negedge rst_n) begin
        bit acc, ack, n_dv, n_mw;
        if (!rst_n) begin
            mq.delete();
            exp_dv   = 1'b0;
            exp_mw   = 1'b0;
            exp_addr = '0;
            exp_data = '0;
        end else begin
            acc  = model_accept();
            ack  = exp_mw && mem_ack;
            n_mw = exp_mw;
`ifdef POSTED_WRITE_EN
            n_dv = acc;
            if (ack) begin
                void'(mq.pop_front());
                n_mw = 1'b0;
            end else if (!exp_mw && mq.size() > 0) begin
                n_mw     = 1'b1;
                exp_addr = mq[0].a;
                exp_data = mq[0].d;
            end
            if (acc) mq.push_back(st_t'{a: address[31:2], d: data});
`else
            n_dv = ack;
            if (ack) begin
                n_mw = 1'b0;
            end else if (acc) begin
                n_mw     = 1'b1;
                exp_addr = address[31:2];
                exp_data = data;
            end
`endif
            exp_dv = n_dv;
            exp_mw = n_mw;
        end
    end

    // Per-cycle comparison against the model, plus bus/pulse bookkeeping.
    always @(negedge clk) begin
        if (rst_n) begin
            check("data_valid", data_valid, exp_dv);
            check("mem_write", mem_write, exp_mw);
            check("mem_address", mem_address, exp_addr);
            check("mem_data", mem_data, exp_data);
            check("drained", drained, model_drained());
            check("dv_adjacent", data_valid && prev_dv, 1'b0);
            if (data_valid) begin
                dv_seen++;
                dv_cyc = cyc;
            end
            if (mem_write && !prev_mw) mw_rise_cyc = cyc;
            if (mem_write && mem_ack) bus_log.push_back(st_t'{a: mem_address, d: mem_data});
            prev_dv = data_valid;
            prev_mw = mem_write;
        end else begin
            prev_dv = 1'b0;
            prev_mw = 1'b0;
        end
    end

    // Bus responder: ack arrives ack_delay cycles after mem_write rises.
    always @(posedge clk) begin
        #1;
        if (auto_ack) begin
            if (mem_write) begin
                ack_cnt++;
                mem_ack = (ack_cnt == ack_delay + 1);
            end else begin
                ack_cnt = 0;
                mem_ack = 1'b0;
            end
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] d, input int budget,
                        input bit drop, output bit ok);
        ae      = 1'b1;
        address = a;
        data    = d;
        ok      = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (data_valid) ok = 1'b1;
        end
        @(posedge clk);
        #1;
        if (drop && ok) ae = 1'b0;
    endtask

    task automatic wait_drained(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = drained && !mem_write;
        end
        check(name, ok, 1'b1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[4];
        bit   ok;
        int   base, dvb;

        vecs[0] = '{a: 32'h0000_1004, d: 32'hDEAD_BEEF, dly: 3, w: 30'h0000_0401};
        vecs[1] = '{a: 32'h0000_0000, d: 32'h0000_0000, dly: 0, w: 30'h0000_0000};
        vecs[2] = '{a: 32'hFFFF_FFFF, d: 32'h1234_5678, dly: 1, w: 30'h3FFF_FFFF};
        vecs[3] = '{a: 32'h0000_0103, d: 32'hA5A5_A5A5, dly: 5, w: 30'h0000_0040};

        rst_n = 1'b0; ae = 1'b0; address = '0; data = '0; mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("reset_data_valid", data_valid, 1'b0);
        check("reset_mem_write", mem_write, 1'b0);
        check("reset_mem_address", mem_address, 30'h0);
        check("reset_mem_data", mem_data, 32'h0);
        check("reset_drained", drained, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single stores with varied ack latency.
        auto_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ack_delay = vecs[i].dly;
            base = bus_log.size();
            dvb  = dv_seen;
            send(vecs[i].a, vecs[i].d, 20, 1'b1, ok);
            check("store_acked", ok, 1'b1);
            wait_drained("store_drain");
            check("bus_count", bus_log.size() - base, 1);
            check("bus_addr", bus_log[bus_log.size()-1].a, vecs[i].w);
            check("bus_data", bus_log[bus_log.size()-1].d, vecs[i].d);
            check("dv_count", dv_seen - dvb, 1);
`ifndef POSTED_WRITE_EN
            check("rise_to_dv", dv_cyc - mw_rise_cyc, vecs[i].dly + 1);
`endif
        end

        // address_enable held high across two distinct stores.
        ack_delay = 1;
        base = bus_log.size();
        dvb  = dv_seen;
        send(32'h0000_2000, 32'h1111_1111, 20, 1'b0, ok);
        check("held_first", ok, 1'b1);
        send(32'h0000_2004, 32'h2222_2222, 20, 1'b1, ok);
        check("held_second", ok, 1'b1);
        wait_drained("held_drain");
        check("held_dv_count", dv_seen - dvb, 2);
        check("held_bus_count", bus_log.size() - base, 2);
        check("held_addr0", bus_log[base].a, 30'h0000_0800);
        check("held_addr1", bus_log[base+1].a, 30'h0000_0801);

        // Spurious ack while idle.
        auto_ack = 1'b0;
        base = bus_log.size();
        dvb  = dv_seen;
        mem_ack = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        mem_ack = 1'b0;
        check("spurious_dv", dv_seen - dvb, 0);
        check("spurious_bus", bus_log.size() - base, 0);
        check("spurious_drained", drained, 1'b1);

`ifdef POSTED_WRITE_EN
        // Six stores into a 4-deep FIFO with the bus stalled.
        base = bus_log.size();
        dvb  = dv_seen;
        for (int i = 0; i < 4; i++) begin
            send(32'h100 + 32'(4 * i), 32'hC0DE_0000 + 32'(i), 5, 1'b0, ok);
            check("posted_fill", ok, 1'b1);
        end
        send(32'h110, 32'hC0DE_0004, 20, 1'b0, ok);
        check("posted_full_withheld", ok, 1'b0);
        check("posted_dv_count", dv_seen - dvb, 4);
        ack_delay = 0;
        auto_ack  = 1'b1;
        send(32'h110, 32'hC0DE_0004, 20, 1'b0, ok);
        check("posted_fifth", ok, 1'b1);
        send(32'h114, 32'hC0DE_0005, 20, 1'b1, ok);
        check("posted_sixth", ok, 1'b1);
        wait_drained("posted_drain");
        check("posted_bus_count", bus_log.size() - base, 6);
        for (int i = 0; i < 6; i++) begin
            check("posted_order", bus_log[base+i].a, 30'h40 + 30'(i));
        end
        auto_ack = 1'b0;
        mem_ack  = 1'b0;
        send(32'h300, 32'h3333_0000, 5, 1'b0, ok);
        check("reset_prep_a", ok, 1'b1);
        send(32'h304, 32'h3333_0001, 5, 1'b0, ok);
        check("reset_prep_b", ok, 1'b1);
`else
        send(32'h300, 32'h3333_0000, 5, 1'b0, ok);
        check("wt_no_ack_no_dv", ok, 1'b0);
`endif
        check("reset_prep_busy", mem_write, 1'b1);

        // Asynchronous reset mid-write.
        #3;
        ae    = 1'b0;
        rst_n = 1'b0;
        #1;
        check("areset_mem_write", mem_write, 1'b0);
        check("areset_data_valid", data_valid, 1'b0);
        check("areset_drained", drained, 1'b1);
        #2;
        rst_n = 1'b1;
        base = bus_log.size();
        repeat (6) begin
            @(negedge clk);
            check("no_stale_write", mem_write, 1'b0);
        end
        check("no_stale_bus", bus_log.size() - base, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
